// File: rtl/coeff_mem_server.sv
`timescale 1ns/1ps
// coeff_mem_server: FIR coefficient memory responder.
// A host streams bytes (little-endian within a word) into DEPTH words; the FIR
// reads them back with one cycle of latency. Optional macro COEFF_MEM_RDCHK_EN
// masks reads issued before the memory is fully loaded and flags them on rd_err.
//
// state | meaning
// IDLE  | after reset, nothing loaded
// LOAD  | accepting bytes into memory
// READY | all DEPTH words loaded, memory valid
module coeff_mem_server #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 64,
    parameter int DEPTH  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic [7:0]        load_rsc_dat,
    input  logic              load_rsc_vld,
    output logic              load_rsc_rdy,
    input  logic [ADDR_W-1:0] coeffs_rsc_radr,
    input  logic              coeffs_rsc_re,
    output logic [DATA_W-1:0] coeffs_rsc_q,
    input  logic              coeffs_triosy_lz,
    output logic              mem_ready,
    output logic [7:0]        done_cnt,
    output logic              rd_err
);

    localparam int NB   = DATA_W / 8;
    localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BI_W-1:0]   LAST_BYTE = BI_W'(NB - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, READY} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [BI_W-1:0]     byte_idx_q, byte_idx_d;
    logic [DATA_W-1:0]   word_buf_q, word_buf_d;
    logic [DATA_W-1:0]   q_q, q_d;
    logic [7:0]          done_cnt_q, done_cnt_d;
    logic [DATA_W-1:0]   word_asm;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    assign load_rsc_rdy = (state_q == LOAD) && !load_start;
    assign mem_ready    = (state_q == READY);
    assign coeffs_rsc_q = q_q;
    assign done_cnt     = done_cnt_q;

    // Load FSM: next state, write pointer and byte assembly
    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        byte_idx_d = byte_idx_q;
        word_buf_d = word_buf_q;
        mem_we     = 1'b0;
        word_asm   = word_buf_q;
        word_asm[{byte_idx_q, 3'b000} +: 8] = load_rsc_dat;
        case (state_q)
            IDLE, READY: begin
                if (load_start) begin
                    state_d    = LOAD;
                    wr_addr_d  = '0;
                    byte_idx_d = '0;
                end
            end
            LOAD: begin
                if (load_start) begin
                    // restart discards any partially assembled word
                    wr_addr_d  = '0;
                    byte_idx_d = '0;
                end else if (load_rsc_vld) begin
                    word_buf_d = word_asm;
                    if (byte_idx_q == LAST_BYTE) begin
                        mem_we     = 1'b1;
                        byte_idx_d = '0;
                        wr_addr_d  = wr_addr_q + ADDR_W'(1);
                        if (wr_addr_q == LAST_ADDR) state_d = READY;
                    end else begin
                        byte_idx_d = byte_idx_q + BI_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Read data, saturating invocation counter and optional read check
`ifdef COEFF_MEM_RDCHK_EN
    logic rd_err_q, rd_err_d;
    assign rd_err = rd_err_q;

    always_comb begin
        q_d      = q_q;
        rd_err_d = rd_err_q;
        if (load_start) rd_err_d = 1'b0;
        if (coeffs_rsc_re) begin
            if (mem_ready) begin
                q_d = mem_q[coeffs_rsc_radr];
            end else begin
                q_d      = '0;
                rd_err_d = 1'b1;
            end
        end
    end

    // Sticky read-before-ready flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rd_err_q <= 1'b0;
        else      rd_err_q <= rd_err_d;
    end
`else
    assign rd_err = 1'b0;

    always_comb begin
        q_d = q_q;
        if (coeffs_rsc_re) q_d = mem_q[coeffs_rsc_radr];
    end
`endif

    // Saturating count of end-of-invocation strobes
    always_comb begin
        done_cnt_d = done_cnt_q;
        if (coeffs_triosy_lz && (done_cnt_q != 8'hFF)) done_cnt_d = done_cnt_q + 8'd1;
    end

    // Control and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            byte_idx_q <= '0;
            word_buf_q <= '0;
            q_q        <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            byte_idx_q <= byte_idx_d;
            word_buf_q <= word_buf_d;
            q_q        <= q_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    // Storage array; contents survive reset, read and write share the edge so reads see the old word
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_addr_q] <= word_asm;
    end

endmodule

// File: tb/tb_coeff_mem_server.sv
`timescale 1ns/1ps
// Directed bench for coeff_mem_server: load, restart, readback, hold,
// read-first collision, done_cnt saturation and mid-load reset.
module tb_coeff_mem_server;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [7:0]  load_rsc_dat;
    logic        load_rsc_vld;
    logic        load_rsc_rdy;
    logic [4:0]  coeffs_rsc_radr;
    logic        coeffs_rsc_re;
    logic [63:0] coeffs_rsc_q;
    logic        coeffs_triosy_lz;
    logic        mem_ready;
    logic [7:0]  done_cnt;
    logic        rd_err;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [63:0] WORD0 = 64'h0706050403020100;
    localparam logic [63:0] WORD1 = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] WORD2 = 64'h1716151413121110;
    localparam logic [63:0] WORD3 = 64'h1F1E1D1C1B1A1918;
    localparam logic [63:0] WORDA = 64'hAAAAAAAAAAAAAAAA;

    coeff_mem_server dut (
        .clk              (clk),
        .rst              (rst),
        .load_start       (load_start),
        .load_rsc_dat     (load_rsc_dat),
        .load_rsc_vld     (load_rsc_vld),
        .load_rsc_rdy     (load_rsc_rdy),
        .coeffs_rsc_radr  (coeffs_rsc_radr),
        .coeffs_rsc_re    (coeffs_rsc_re),
        .coeffs_rsc_q     (coeffs_rsc_q),
        .coeffs_triosy_lz (coeffs_triosy_lz),
        .mem_ready        (mem_ready),
        .done_cnt         (done_cnt),
        .rd_err           (rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},  {63'd0, load_rsc_rdy}, 64'd0);
        chk({tag, "_q"},    coeffs_rsc_q, 64'd0);
        chk({tag, "_mrdy"}, {63'd0, mem_ready}, 64'd0);
        chk({tag, "_done"}, {56'd0, done_cnt}, 64'd0);
        chk({tag, "_err"},  {63'd0, rd_err}, 64'd0);
    endtask

    // One-cycle load_start with a valid byte that must not be consumed
    task automatic pulse_start();
        load_start   = 1'b1;
        load_rsc_vld = 1'b1;
        load_rsc_dat = 8'hEE;
        #1;
        chk("rdy_on_start", {63'd0, load_rsc_rdy}, 64'd0);
        step();
        load_start   = 1'b0;
        load_rsc_vld = 1'b0;
    endtask

    // Stream bytes first..last; byte n of the load carries n (or 0xAA)
    task automatic feed(input int first, input int last, input bit rnd, input bit aa);
        int cnt = first;
        int cyc = 0;
        bit v;
        while (cnt <= last && cyc < 3000) begin
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            load_rsc_vld = v;
            load_rsc_dat = aa ? 8'hAA : 8'(cnt);
            #1;
            chk("rdy_load", {63'd0, load_rsc_rdy}, 64'd1);
            if (cnt == 255 && v) chk("mrdy_before_last", {63'd0, mem_ready}, 64'd0);
            step();
            if (v) cnt++;
            cyc++;
        end
        load_rsc_vld = 1'b0;
        chk("feed_count", 64'(cnt), 64'(last + 1));
    endtask

    task automatic rd(input logic [4:0] a);
        coeffs_rsc_re   = 1'b1;
        coeffs_rsc_radr = a;
        step();
        coeffs_rsc_re   = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        load_start = 1'b0;
        load_rsc_dat = 8'h00;
        load_rsc_vld = 1'b0;
        coeffs_rsc_radr = '0;
        coeffs_rsc_re = 1'b0;
        coeffs_triosy_lz = 1'b0;
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        step();

        // read before any load
        rd(5'd5);
`ifdef COEFF_MEM_RDCHK_EN
        chk("early_rd_q", coeffs_rsc_q, 64'd0);
        chk("early_rd_err", {63'd0, rd_err}, 64'd1);
`else
        chk("early_rd_err", {63'd0, rd_err}, 64'd0);
`endif

        // full load, with restart after 13 bytes
        pulse_start();
        chk("start_clears_err", {63'd0, rd_err}, 64'd0);
        chk("mrdy_loading", {63'd0, mem_ready}, 64'd0);
        feed(0, 12, 1'b0, 1'b0);
        pulse_start();
        feed(0, 255, 1'b0, 1'b0);
        chk("mrdy_after_load", {63'd0, mem_ready}, 64'd1);
        chk("rdy_after_load", {63'd0, load_rsc_rdy}, 64'd0);

        // readback, back-to-back, hold
        rd(5'd3);
        chk("rd3", coeffs_rsc_q, WORD3);
        coeffs_rsc_re = 1'b1;
        coeffs_rsc_radr = 5'd1; step();
        chk("b2b_1", coeffs_rsc_q, WORD1);
        coeffs_rsc_radr = 5'd2; step();
        chk("b2b_2", coeffs_rsc_q, WORD2);
        coeffs_rsc_radr = 5'd3; step();
        chk("b2b_3", coeffs_rsc_q, WORD3);
        coeffs_rsc_re = 1'b0;
        coeffs_rsc_radr = 5'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("hold", coeffs_rsc_q, WORD3);
        end
        rd(5'd0);
        chk("rd0", coeffs_rsc_q, WORD0);
        chk("err_ready", {63'd0, rd_err}, 64'd0);

        // done_cnt saturation
        coeffs_triosy_lz = 1'b1;
        step();
        chk("done_1", {56'd0, done_cnt}, 64'd1);
        repeat (254) step();
        chk("done_255", {56'd0, done_cnt}, 64'd255);
        repeat (45) step();
        coeffs_triosy_lz = 1'b0;
        chk("done_sat", {56'd0, done_cnt}, 64'd255);

        // reload with 0xAA, random backpressure, read word 0 as it is written
        pulse_start();
        feed(0, 6, 1'b0, 1'b1);
        load_rsc_vld = 1'b1;
        load_rsc_dat = 8'hAA;
        coeffs_rsc_re = 1'b1;
        coeffs_rsc_radr = 5'd0;
        step();
        coeffs_rsc_re = 1'b0;
        load_rsc_vld = 1'b0;
`ifdef COEFF_MEM_RDCHK_EN
        chk("collide_q", coeffs_rsc_q, 64'd0);
`else
        chk("collide_q", coeffs_rsc_q, WORD0);
`endif
        feed(8, 255, 1'b1, 1'b1);
        chk("mrdy_reload", {63'd0, mem_ready}, 64'd1);
        rd(5'd0);
        chk("rd0_new", coeffs_rsc_q, WORDA);
`ifdef COEFF_MEM_RDCHK_EN
        chk("err_sticky", {63'd0, rd_err}, 64'd1);
`else
        chk("err_tied", {63'd0, rd_err}, 64'd0);
`endif

        // reset in the middle of a load
        pulse_start();
        chk("err_cleared", {63'd0, rd_err}, 64'd0);
        feed(0, 20, 1'b0, 1'b0);
        load_rsc_vld = 1'b1;
        rst = 1'b0;
        #1;
        check_reset_outputs("midload");
        step();
        rst = 1'b1;
        step();
        step();
        chk("idle_after_rst", {63'd0, load_rsc_rdy}, 64'd0);
        load_rsc_vld = 1'b0;

        // memory survives reset; word 4 still holds the 0xAA load
        rd(5'd4);
`ifdef COEFF_MEM_RDCHK_EN
        chk("post_rst_rd", coeffs_rsc_q, 64'd0);
        chk("post_rst_err", {63'd0, rd_err}, 64'd1);
`else
        chk("post_rst_rd", coeffs_rsc_q, WORDA);
        rd(5'd1);
        chk("post_rst_rd1", coeffs_rsc_q, WORD1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
